// File: rtl/ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// ex_stage_pkg
// Shared definitions for the execute stage: default datapath width, the ALU
// operation codes and the legality check used by the ALU-control decoder.
// No ports (package).
// -----------------------------------------------------------------------------
package ex_stage_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110
  } alu_op_e;

  // Only the four codes above are legal; anything else (including X in
  // simulation) falls through to the default branch and is flagged.
  function automatic logic alu_op_legal(input logic [3:0] op);
    logic ok;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB: ok = 1'b1;
      default:                           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// -----------------------------------------------------------------------------
// ex_stage_if
// Bundles the ID/EX inputs and EX/MEM outputs of the execute stage.
//   slave  : used by ex_stage (consumes ID/EX fields, drives EX/MEM fields)
//   master : used by the upstream driver (drives ID/EX, observes EX/MEM)
// ID/EX : inValid, stall, flush, aluControl, readData1, readData2, imm, pc,
//         aluSrc, branch, memRead, memWrite, memToReg, regWrite, rd
// EX/MEM: outValid, aluResult, zero, writeData, branchTarget, pcSrc,
//         memReadOut, memWriteOut, memToRegOut, regWriteOut, rdOut, illegalOp
// -----------------------------------------------------------------------------
interface ex_stage_if
  import ex_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);

  logic            inValid;
  logic            stall;
  logic            flush;
  logic [3:0]      aluControl;
  logic [XLEN-1:0] readData1;
  logic [XLEN-1:0] readData2;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc;
  logic            aluSrc;
  logic            branch;
  logic            memRead;
  logic            memWrite;
  logic            memToReg;
  logic            regWrite;
  logic [4:0]      rd;

  logic            outValid;
  logic [XLEN-1:0] aluResult;
  logic            zero;
  logic [XLEN-1:0] writeData;
  logic [XLEN-1:0] branchTarget;
  logic            pcSrc;
  logic            memReadOut;
  logic            memWriteOut;
  logic            memToRegOut;
  logic            regWriteOut;
  logic [4:0]      rdOut;
  logic            illegalOp;

  modport master (
    output inValid, stall, flush, aluControl, readData1, readData2, imm, pc,
           aluSrc, branch, memRead, memWrite, memToReg, regWrite, rd,
    input  outValid, aluResult, zero, writeData, branchTarget, pcSrc,
           memReadOut, memWriteOut, memToRegOut, regWriteOut, rdOut, illegalOp
  );

  modport slave (
    input  inValid, stall, flush, aluControl, readData1, readData2, imm, pc,
           aluSrc, branch, memRead, memWrite, memToReg, regWrite, rd,
    output outValid, aluResult, zero, writeData, branchTarget, pcSrc,
           memReadOut, memWriteOut, memToRegOut, regWriteOut, rdOut, illegalOp
  );

endinterface

// File: rtl/ex_stage_alu.sv
// -----------------------------------------------------------------------------
// alu
// Combinational ALU for the execute stage.
//   a, b       : XLEN-bit operands
//   aluControl : 4-bit operation code (and / or / add / sub)
//   result     : XLEN-bit result, modulo 2^XLEN; forced to 0 on illegal codes
//   zero       : result == 0
//   illegal    : aluControl is not one of the legal codes
// -----------------------------------------------------------------------------
module alu
  import ex_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      aluControl,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  logic [XLEN-1:0] result_s;
  logic            illegal_s;

  // Operation select; carries and overflow simply fall off the top bit.
  always_comb begin
    result_s  = '0;
    illegal_s = ~alu_op_legal(aluControl);
    case (aluControl)
      ALU_AND: result_s = a & b;
      ALU_OR:  result_s = a | b;
      ALU_ADD: result_s = a + b;
      ALU_SUB: result_s = a - b;
      default: result_s = '0;
    endcase
  end

  assign result  = result_s;
  assign zero    = (result_s == '0);
  assign illegal = illegal_s;

endmodule

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
// Execute stage of the pipeline: selects ALU operand B, runs the ALU, computes
// the branch target and registers everything into the EX/MEM slot one cycle
// later.
//   clk : single clock, rising-edge
//   rst : synchronous active-high reset, clears the whole EX/MEM slot
//   bus : ex_stage_if.slave (ID/EX inputs, EX/MEM registered outputs)
// Per-edge priority: rst, then stall (hold), then flush / empty slot (bubble),
// then normal capture.
// -----------------------------------------------------------------------------
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  ex_stage_if.slave bus
);

  logic [XLEN-1:0] opb_s;
  logic [XLEN-1:0] alu_res_s;
  logic            alu_zero_s;
  logic            alu_ill_s;
  logic [XLEN-1:0] br_tgt_s;
  logic            capture_s;
  logic            legal_s;

  logic            out_valid_r;
  logic [XLEN-1:0] alu_result_r;
  logic            zero_r;
  logic [XLEN-1:0] write_data_r;
  logic [XLEN-1:0] branch_target_r;
  logic            pc_src_r;
  logic            mem_read_r;
  logic            mem_write_r;
  logic            mem_to_reg_r;
  logic            reg_write_r;
  logic [4:0]      rd_r;
  logic            illegal_r;

  // Operand B mux: immediate or rs2.
  always_comb begin
    opb_s = bus.readData2;
    if (bus.aluSrc) begin
      opb_s = bus.imm;
    end else begin
      opb_s = bus.readData2;
    end
  end

  alu #(.XLEN(XLEN)) u_alu (
    .a          (bus.readData1),
    .b          (opb_s),
    .aluControl (bus.aluControl),
    .result     (alu_res_s),
    .zero       (alu_zero_s),
    .illegal    (alu_ill_s)
  );

  // Branch target is computed for every instruction; offset is a halfword count.
  always_comb begin
    br_tgt_s = bus.pc + (bus.imm << 1);
  end

  // A flushed or empty slot becomes a bubble; an illegal op keeps the slot
  // live but must not produce any architectural side effect.
  always_comb begin
    capture_s = bus.inValid & ~bus.flush;
    legal_s   = capture_s & ~alu_ill_s;
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r     <= 1'b0;
      alu_result_r    <= '0;
      zero_r          <= 1'b0;
      write_data_r    <= '0;
      branch_target_r <= '0;
      pc_src_r        <= 1'b0;
      mem_read_r      <= 1'b0;
      mem_write_r     <= 1'b0;
      mem_to_reg_r    <= 1'b0;
      reg_write_r     <= 1'b0;
      rd_r            <= 5'd0;
      illegal_r       <= 1'b0;
    end else if (!bus.stall) begin
      out_valid_r     <= capture_s;
      alu_result_r    <= alu_res_s;
      zero_r          <= alu_zero_s;
      write_data_r    <= bus.readData2;
      branch_target_r <= br_tgt_s;
      pc_src_r        <= legal_s & bus.branch & alu_zero_s;
      mem_read_r      <= legal_s & bus.memRead;
      mem_write_r     <= legal_s & bus.memWrite;
      mem_to_reg_r    <= capture_s & bus.memToReg;
      reg_write_r     <= legal_s & bus.regWrite;
      rd_r            <= bus.rd;
      illegal_r       <= capture_s & alu_ill_s;
    end
  end

  assign bus.outValid     = out_valid_r;
  assign bus.aluResult    = alu_result_r;
  assign bus.zero         = zero_r;
  assign bus.writeData    = write_data_r;
  assign bus.branchTarget = branch_target_r;
  assign bus.pcSrc        = pc_src_r;
  assign bus.memReadOut   = mem_read_r;
  assign bus.memWriteOut  = mem_write_r;
  assign bus.memToRegOut  = mem_to_reg_r;
  assign bus.regWriteOut  = reg_write_r;
  assign bus.rdOut        = rd_r;
  assign bus.illegalOp    = illegal_r;

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 inValid  input  1  ID/EX slot carries a live instruction.
REQ-005 stall  input  1  hold EX/MEM register contents unchanged this cycle.
REQ-006 flush  input  1  squash the instruction being captured this cycle.
REQ-007 aluControl  input  4  operation code: 0000 and, 0001 or, 0010 add, 0110 sub.
REQ-008 readData1 / readData2  input  XLEN  register-file operands rs1 / rs2.
REQ-009 imm  input  XLEN  sign-extended immediate.
REQ-010 pc  input  XLEN  instruction address.
REQ-011 aluSrc, branch, memRead, memWrite, memToReg, regWrite  input  1 each  control bits from the main decoder.
REQ-012 rd  input  5  destination register index.
REQ-013 outValid  output  1  EX/MEM slot live.
REQ-014 aluResult  output  XLEN  registered ALU result.
REQ-015 zero  output  1  registered (aluResult == 0).
REQ-016 writeData  output  XLEN  registered readData2 (store data).
REQ-017 branchTarget  output  XLEN  registered pc + (imm << 1).
REQ-018 pcSrc  output  1  registered branch-taken (branch & zero of the captured op).
REQ-019 memReadOut, memWriteOut, memToRegOut, regWriteOut  output  1 each; rdOut  output  5  registered copies of the control bits and rd.
REQ-020 illegalOp  output  1  registered flag: captured aluControl not one of the four legal codes.

Function
REQ-021 Operand B SHALL be imm when aluSrc=1, else readData2.
REQ-022 Arithmetic SHALL be modulo 2^XLEN; carry and overflow are discarded.
REQ-023 All outputs SHALL be registered, latency exactly one cycle from input to output.
REQ-024 Priority per edge: rst > stall > flush > normal capture.
REQ-025 stall=1 (rst=0): every output register SHALL hold its value, regardless of flush or inValid.
REQ-026 flush=1, stall=0: outValid, pcSrc, memReadOut, memWriteOut, regWriteOut, illegalOp SHALL load 0; datapath registers are don't-care.
REQ-027 inValid=0, stall=0: same as flush (bubble inserted).
REQ-028 Illegal aluControl (any code other than 0000/0001/0010/0110, including X): aluResult=0, zero=1, illegalOp=1, regWriteOut=0, memReadOut=0, memWriteOut=0, pcSrc=0, outValid=1.
REQ-029 pcSrc SHALL assert only when outValid is loaded 1, branch=1 and the computed result is zero.
REQ-030 branchTarget SHALL be computed irrespective of branch; offset shift is a logical left shift by 1, truncated to XLEN.
REQ-031 Stall and flush in the same cycle SHALL behave as stall; the flush is lost and must be reasserted by hazard logic.

Reset
REQ-032 On rst=1 at a rising edge, all outputs SHALL load 0 (outValid=0, zero=0, illegalOp=0), overriding stall and flush.
REQ-033 Reset asserted mid-stall SHALL clear the held instruction; first capture occurs on the first edge with rst=0.

Structure
REQ-034 A shared package SHALL hold the aluControl codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB) and the XLEN default, also used by the ALU-control decoder.
REQ-035 The combinational ALU SHALL be a sub-module named alu (inputs a, b, aluControl; outputs result, zero, illegal); ex_stage contains operand mux, branch adder and EX/MEM register.

Verification
REQ-036 Add: aluControl=0010, aluSrc=1, readData1=5, imm=-5 -> next cycle aluResult=0, zero=1, regWriteOut as driven, outValid=1.
REQ-037 Beq taken: aluControl=0110, branch=1, readData1=readData2=0x1234, pc=0x100, imm=8 -> pcSrc=1, branchTarget=0x110; with readData2=0x1235 -> pcSrc=0.
REQ-038 Wrap: sub 0 - 1 -> aluResult=all ones, zero=0; and/or of 0xF0F0/0x0FF0 -> 0x00F0 / 0xFFF0.
REQ-039 Stall/flush: capture add, assert stall 3 cycles while changing inputs -> outputs unchanged; stall+flush -> unchanged; flush alone -> outValid=0, regWriteOut=0, memWriteOut=0.
REQ-040 Illegal: aluControl=0111 with regWrite=1, memWrite=1 -> illegalOp=1, aluResult=0, regWriteOut=0, memWriteOut=0.
REQ-041 Reset during stall with outValid=1 -> next edge all outputs 0; following edge captures new input normally.
